// File: rtl/disp_pkg.sv
// disp_pkg: shared constants, segment encodings and history slot type for the display stage
package disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_CODES [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef struct packed {
    logic [3:0] value;
    logic       valid;
    logic       wrap;
  } slot_t;
endpackage

// File: rtl/counter_hist_display_if.sv
// counter_hist_display_if: counter sample inputs and seven-segment display pins
interface counter_hist_display_if;
  logic [3:0] Q_in;
  logic       freeze;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  modport master (output Q_in, freeze, input an, seg, dp);
  modport slave (input Q_in, freeze, output an, seg, dp);
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: hex digit to active-low segments, blank when the slot is empty
module seg7_decoder
  import disp_pkg::*;
(
  input  logic [3:0] value,
  input  logic       valid,
  output logic [6:0] seg
);
  assign seg = valid ? SEG_CODES[value] : SEG_BLANK;
endmodule

// File: rtl/counter_hist_display.sv
// counter_hist_display: 4-entry change history of the counter shown on a multiplexed 7-seg display
module counter_hist_display
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input logic clk,
  input logic reset,
  counter_hist_display_if.slave bus
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  slot_t hist [NUM_DIGITS];
  slot_t cur;
  logic [3:0] q_prev;
  logic primed;
  logic push;
  logic tc;
  logic [DW-1:0] div_cnt;
  logic [IW-1:0] idx;
  logic [6:0] seg_d;
  assign push = !bus.freeze && (!primed || bus.Q_in != q_prev);
  assign tc = div_cnt == DW'(REFRESH_DIV - 1);
  assign cur = hist[idx];
  seg7_decoder u_dec (
    .value(cur.value),
    .valid(cur.valid),
    .seg  (seg_d)
  );
  // History shift on each new value; q_prev tracks even while frozen so held changes are dropped
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) hist[i] <= '0;
      q_prev <= '0;
      primed <= 1'b0;
    end else begin
      if (push) begin
        hist[0] <= '{value: bus.Q_in, valid: 1'b1, wrap: bus.Q_in == 4'd0 && q_prev == 4'd15};
        for (int i = 1; i < NUM_DIGITS; i++) hist[i] <= hist[i-1];
      end
      q_prev <= bus.Q_in;
      primed <= primed | !bus.freeze;
    end
  // Refresh divider, scan index and registered pins so an/seg/dp always switch together
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div_cnt <= '0;
      idx <= '0;
      bus.an <= 4'b1110;
      bus.seg <= SEG_BLANK;
      bus.dp <= 1'b1;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + DW'(1);
      idx <= tc ? idx + IW'(1) : idx;
      bus.an <= ~(NUM_DIGITS'(1) << idx);
      bus.seg <= seg_d;
      bus.dp <= ~(cur.valid & cur.wrap);
    end
endmodule

// File: doc/counter_hist_display.md
# counter_hist_display

Downstream display stage for the 4-bit counter: samples the counter's `Q` output every clock and records each new value in a 4-entry history (newest first). It drives a 4-digit, common-anode, time-multiplexed seven-segment display with that history. Each 15→0 wrap is flagged on the decimal point of the entry that recorded it. The block sits between the counter and the board display pins.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays enabled before the scan advances; legal range ≥ 2.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state.
- `Q_in`  in  4  count value from the upstream 4-bit counter.
- `freeze`  in  1  when 1, history updates are suppressed; the scan continues.
- `an`  out  4  digit enables, active-low, one-hot-low.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- **History:** four slots, `hist[0]` newest to `hist[3]` oldest. Each slot holds a value[3:0], a valid bit and a wrap bit.
- **Push:** `hist[0]` ← new entry; `hist[i]` ← `hist[i-1]`; the old `hist[3]` is discarded.
  - The new entry has valid=1.
  - Its wrap bit = (`Q_in`==0 && `q_prev`==15).
- **Push condition:** `freeze`==0 and either:
  - first sample after reset (`primed`==0), or
  - `Q_in` != `q_prev`.
- **Change tracking:**
  - `q_prev` ← `Q_in` every cycle, including while frozen. A value that changed during freeze is therefore not pushed on release.
  - `primed` is set on the first edge after reset and stays set.
  - While `freeze`==1, `primed` stays 0 if it was 0, so the first unfrozen sample still pushes.
- **Scan:**
  - `div_cnt` counts 0..`REFRESH_DIV`-1.
  - At terminal count it wraps to 0, and `idx` advances 0→1→2→3→0.
- **Output register** (updated every cycle from current `idx` and `hist`):
  - `an` = ~(1<<`idx`).
  - `seg` = hex decode of `hist[idx]`.value when valid, else 7'b1111111 (blank).
  - `dp` = ~(valid && wrap) of `hist[idx]`.
- **Decode, active-low:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- **Simultaneous events:** a push and a scan advance in the same cycle are independent. The output register then reflects both on the following edge.

## Timing
- **Reset values** (held while `reset`==0, applied asynchronously):
  - `an`=4'b1110, `seg`=7'b1111111, `dp`=1.
  - `idx`=0, `div_cnt`=0, `q_prev`=0, `primed`=0.
  - All slots valid=0, wrap=0.
- **Push latency:** a `Q_in` change sampled at edge k is in `hist[0]` after edge k. It appears on `seg` at edge k+1 if `idx`==0.
- **Scan period:** `an` changes at the edge after `div_cnt` reaches terminal.
  - `an`, `seg` and `dp` always change on the same edge, so there is no cross-digit glitch.
  - Each digit is enabled for exactly `REFRESH_DIV` cycles.
- **Reset mid-operation:** asserting reset returns all outputs and state to reset values immediately, regardless of `idx` or `freeze`.
- **Post-reset bring-up:**
  - The first edge after reset release pushes `Q_in` (unless `freeze`==1).
  - The second edge displays it on digit 0.

## Structure
- **Shared package `disp_pkg`:**
  - `NUM_DIGITS`=4
  - `SEG_BLANK`=7'b1111111
  - the 16 segment encodings
  - history-slot struct {value[3:0], valid, wrap}
- **Sub-module `seg7_decoder`:** purely combinational, 4-bit value + valid in, 7-bit active-low segments out. Instantiated once, on the `hist[idx]` mux output.
- The remaining logic (history shift register, change detector, refresh divider, scan index, output register) stays in the top module.

## Test plan
Run all scenarios with `REFRESH_DIV`=4.
1. **Reset and bring-up:** hold reset low, `Q_in`=3 → `an`=1110, `seg`=1111111, `dp`=1. Release → after 2 edges `seg`=0110000 on digit 0; digits 1–3 blank.
2. **Scan order:** no `Q_in` change → `an` cycles 1110, 1101, 1011, 0111, 1110, 4 cycles each, aligned with `seg` changes.
3. **Wrap flag:** `Q_in` 14→15→0, each held 2 cycles → values `hist`={0,F,E,3}. Digit 0 shows 1000000 with `dp`=0; digits 1–3 have `dp`=1.
4. **Held value:** `Q_in` constant 7 for 100 cycles after one push → exactly one push; `hist[1..3]` unchanged.
5. **Freeze:** `freeze`=1 while `Q_in` goes 5→6→7 → history unchanged. Release with `Q_in`=7 stable → no push. `Q_in`=8 → 8 pushed to digit 0.
6. **Reset mid-scan:** assert reset while `idx`=2 → outputs go to reset values without a clock edge; after release all slots are blank except the new first push.
